// File: rtl/apb_bridge_master.sv
// Request-to-APB bridge: one outstanding read/write, SETUP/ACCESS sequencing,
// wait-state timeout and a one-cycle response strobe with read data/error.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_write/req_addr/req_wdata : command port
//   rsp_valid/rsp_rdata/rsp_err                      : completion strobe
//   paddr/pwrite/psel/penable/pwdata/prdata/pready   : APB master side
module apb_bridge_master #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDRWIDTH-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [DATAWIDTH-1:0] pwdata,
  input  logic [DATAWIDTH-1:0] prdata,
  input  logic                 pready
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]        cnt, cnt_n;
  logic [ADDRWIDTH-1:0] paddr_n;
  logic                 pwrite_n;
  logic [DATAWIDTH-1:0] pwdata_n;
  logic                 psel_n;
  logic                 penable_n;
  logic                 rsp_valid_n;
  logic [DATAWIDTH-1:0] rsp_rdata_n;
  logic                 rsp_err_n;

  // state is IDLE during reset, so req_ready reads 1 there too
  assign req_ready = (state == IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    paddr_n     = paddr;
    pwrite_n    = pwrite;
    pwdata_n    = pwdata;
    psel_n      = psel;
    penable_n   = penable;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          paddr_n   = req_addr;
          pwrite_n  = req_write;
          pwdata_n  = req_write ? req_wdata : '0;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          state_n   = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end
      ACCESS: begin
        // pready wins over the timeout in the same cycle
        if (pready) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = pwrite ? '0 : prdata;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          state_n     = IDLE;
        end else if (cnt == CNT_LAST) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      paddr     <= paddr_n;
      pwrite    <= pwrite_n;
      pwdata    <= pwdata_n;
      psel      <= psel_n;
      penable   <= penable_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule

// File: doc/apb_bridge_master.md
# apb_bridge_master

Request-to-APB bridge that sits directly upstream of the team's APB memory slave. It accepts single read/write commands on a valid/ready request port and sequences them through the APB SETUP/ACCESS phases. It waits on `pready`, bounds each transfer with a wait-state timeout, and returns read data plus an error flag on a one-cycle response strobe. One transfer is outstanding at a time.

## Interface
Parameters:
- `ADDRWIDTH`, 8: width of `req_addr`/`paddr`.
- `DATAWIDTH`, 32: width of all data buses.
- `TIMEOUT`, 16: maximum ACCESS cycles with `pready` low before abort; legal range ≥1.

Ports:
- `clk`  in  1: clock, all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: command present.
- `req_ready`  out  1: bridge can accept; combinational, high iff state is IDLE.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDRWIDTH: target address.
- `req_wdata`  in  DATAWIDTH: write data, ignored on reads.
- `rsp_valid`  out  1: one-cycle completion strobe.
- `rsp_rdata`  out  DATAWIDTH: read data; 0 for writes and timeouts.
- `rsp_err`  out  1: 1 = transfer aborted by timeout; qualified by `rsp_valid`.
- `paddr`  out  ADDRWIDTH: APB address.
- `pwrite`  out  1: APB direction.
- `psel`  out  1: APB select.
- `penable`  out  1: APB enable.
- `pwdata`  out  DATAWIDTH: APB write data.
- `prdata`  in  DATAWIDTH: APB read data.
- `pready`  in  1: APB completion.

## Operation
- States are IDLE, SETUP and ACCESS, in a 2-bit register.
- Wait counter is `$clog2(TIMEOUT)+1` bits and is cleared on every entry to ACCESS.
- **IDLE:**
  - `req_ready`=1, `psel`=0, `penable`=0.
  - A request is accepted when `req_valid` and `req_ready` are both high at the clock edge.
  - On acceptance, register `paddr`←`req_addr`, `pwrite`←`req_write`, and `pwdata`←`req_wdata` (0 on reads).
  - Also on acceptance, set `psel`←1 and `penable`←0, then go to SETUP.
- **SETUP:**
  - Lasts exactly one cycle.
  - Next edge: `penable`←1, counter←0, go to ACCESS.
- **ACCESS:** `pready` is sampled each edge.
  - `pready`=1: complete normally.
    - `rsp_valid`←1, `rsp_err`←0.
    - `rsp_rdata`←`prdata` on reads, 0 on writes.
    - `psel`←0, `penable`←0, go to IDLE.
  - `pready`=0 and counter = TIMEOUT-1: abort.
    - `rsp_valid`←1, `rsp_err`←1, `rsp_rdata`←0.
    - `psel`←0, `penable`←0, go to IDLE.
  - Otherwise: counter+1, stay in ACCESS.
  - `pready`=1 takes priority over timeout in the same cycle.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS, and hold their last values in IDLE.
- `rsp_valid` is high for exactly one cycle per accepted request.
- `rsp_rdata` and `rsp_err` hold their values until the next completion.
- `pready`/`prdata` are ignored outside ACCESS, so a sticky or early `pready` never completes a transfer before ACCESS.
- Reset (asynchronous, any state):
  - State goes to IDLE immediately; the in-flight transfer is dropped and no response is issued.
  - All registered outputs go to 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`.
  - `req_ready` is 1 while in reset.

## Timing
- Acceptance edge E0 → SETUP cycle (`psel`=1, `penable`=0) → edge E1 → ACCESS (`penable`=1).
- Zero wait states: `pready`=1 in the first ACCESS cycle gives completion at E2.
  - `rsp_valid`=1 during cycle E2–E3, `psel` low in the same cycle.
  - Latency from accept to `rsp_valid` is 2 cycles.
- N wait states (N < TIMEOUT): latency 2+N cycles.
- Timeout: `rsp_valid`/`rsp_err` assert 1+TIMEOUT cycles after acceptance.
- Back-to-back:
  - `req_ready` is high in the same cycle as `rsp_valid`.
  - A new request can be accepted at the edge ending the response cycle.
  - Minimum period is 3 cycles per transfer, with `psel` low for exactly one cycle between transfers.
- `req_*` inputs are don't-care except at the acceptance edge.

## Test plan
- **Write then read, zero wait:**
  - Request write addr 0x10 data 0xDEADBEEF with a slave returning `pready`=1 in ACCESS.
  - Required: `psel` high 2 cycles, `penable` high 1 cycle, `rsp_valid` at accept+2, `rsp_err`=0.
  - Then request read 0x10 with `prdata`=0xDEADBEEF → `rsp_rdata`=0xDEADBEEF.
- **Wait states:**
  - Read addr 0x3F with `pready` held low for 5 ACCESS cycles, then high, `prdata`=0x12345678.
  - Required: `rsp_valid` at accept+7, `rsp_rdata`=0x12345678.
  - `paddr` stays 0x3F and `penable` stays 1 throughout.
- **Timeout (TIMEOUT=16):**
  - `pready` never asserted.
  - Required: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 at accept+17; `psel`/`penable` drop the same cycle.
  - Also drive `pready`=1 exactly in the 16th ACCESS cycle → normal completion, `rsp_err`=0.
- **Back-to-back with `req_valid` held high:**
  - Issue 4 writes to addrs 0..3.
  - Required: accepts every 3 cycles, exactly 4 `rsp_valid` pulses, one IDLE cycle between `psel` pulses.
- **Reset mid-ACCESS:**
  - Assert `rst` low asynchronously while `pready`=0.
  - Required: `psel`, `penable` and `rsp_valid` go to 0 without a clock edge, and no response is produced.
  - After release, a read completes normally with `rsp_valid` at accept+2.
- **Early/sticky `pready`:**
  - Hold `pready`=1 continuously.
  - Required: every transfer still spends exactly 1 SETUP cycle and 1 ACCESS cycle, and `rsp_rdata` is captured only in ACCESS.
